// File: rtl/ads_capture_mc.sv
// ads_capture_mc -- multi-channel capture controller for daisy-chained ADCs.
//
// This block waits for a measure pulse and raises START. It then captures
// NUM_FRAMES frames. Each frame holds NUM_CH words of DATA_WIDTH bits. A frame
// is shifted in, MSB first, after every falling edge of the ADC data-ready
// line. Each completed word is presented on data_out/ch_out with a one-cycle
// valid strobe.
//
// Optional feature (macro ADS_CAPTURE_AVG_EN): each channel is accumulated
// over all frames of a run. Only NUM_CH averaged words are emitted, in the
// last frame. NUM_FRAMES must be a power of two in this build.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   measure  in   one-cycle pulse that starts a run (ignored while busy)
//   drdy_n   in   ADC data ready, active low, asynchronous
//   drr      in   serial data from ADC, MSB first
//   start    out  ADC START pin, high while a run is active
//   sclk     out  serial shift clock to the ADC
//   fsx      out  frame sync, high for the first sclk period of a frame
//   data_out out  last completed word
//   ch_out   out  channel index of data_out
//   valid    out  one-cycle strobe qualifying data_out/ch_out
//   busy     out  high from ARM through the last emitted word
//   overrun  out  sticky: data-ready fell while a frame was being shifted
module ads_capture_mc #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CH     = 2,
    parameter int SCLK_DIV   = 2,
    parameter int NUM_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  measure,
    input  logic                  drdy_n,
    input  logic                  drr,
    output logic                  start,
    output logic                  sclk,
    output logic                  fsx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            ch_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FR_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  drdy_meta_r;
    logic                  drdy_sync_r;
    logic                  drdy_prev_r;
    logic                  fall_s;
    logic [DIV_W-1:0]      div_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [2:0]            ch_cnt_r;
    logic [FR_W-1:0]       frame_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  div_hit_s;
    logic                  rise_s;
    logic                  word_done_s;
    logic                  last_ch_s;
    logic                  last_fr_s;
    logic                  start_r;
    logic                  sclk_r;
    logic                  fsx_r;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic [2:0]            ch_out_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  overrun_r;

    // The falling edge is taken between the 2nd synchroniser flop and its
    // delayed copy. A fall therefore acts on the FSM three clocks after drdy_n drops.
    assign fall_s      = drdy_prev_r & ~drdy_sync_r;
    assign div_hit_s   = (div_cnt_r == DIV_W'(SCLK_DIV - 1));
    assign rise_s      = (state_r == ST_SHIFT) && div_hit_s && !sclk_r;
    assign word_done_s = rise_s && (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));
    assign last_ch_s   = (ch_cnt_r == 3'(NUM_CH - 1));
    assign last_fr_s   = (frame_cnt_r == FR_W'(NUM_FRAMES - 1));
    assign word_s      = {shift_r[DATA_WIDTH-2:0], drr};

    assign start    = start_r;
    assign sclk     = sclk_r;
    assign fsx      = fsx_r;
    assign data_out = data_out_r;
    assign ch_out   = ch_out_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

`ifdef ADS_CAPTURE_AVG_EN
    localparam int ACC_W = DATA_WIDTH + 16;
    localparam int AVG_SH = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 0;

    logic signed [ACC_W-1:0] acc_r [0:7];
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] avg_s;

    // Running sum for the channel being completed; frame 0 restarts the sum.
    always_comb begin
        sum_s = {{16{word_s[DATA_WIDTH-1]}}, word_s};
        if (frame_cnt_r != FR_W'(0)) begin
            sum_s = acc_r[ch_cnt_r] + {{16{word_s[DATA_WIDTH-1]}}, word_s};
        end else begin
            sum_s = {{16{word_s[DATA_WIDTH-1]}}, word_s};
        end
        avg_s = sum_s >>> AVG_SH;
    end

    // Per-channel accumulators, updated as each word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                acc_r[i] <= '0;
            end
        end else if (word_done_s) begin
            acc_r[ch_cnt_r] <= sum_s;
        end
    end
`endif

    // Next-state logic; measure is only looked at in IDLE, which is what
    // makes it ignored while busy.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (measure) state_s = ST_ARM;
                else         state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (fall_s) state_s = ST_SHIFT;
                else        state_s = ST_ARM;
            end
            ST_SHIFT: begin
                if (word_done_s) state_s = ST_EMIT;
                else             state_s = ST_SHIFT;
            end
            ST_EMIT: begin
                if (!last_ch_s)      state_s = ST_SHIFT;
                else if (!last_fr_s) state_s = ST_ARM;
                else                 state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, synchroniser, sclk generator, counters and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            drdy_meta_r <= 1'b1;
            drdy_sync_r <= 1'b1;
            drdy_prev_r <= 1'b1;
            div_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            ch_cnt_r    <= 3'd0;
            frame_cnt_r <= '0;
            shift_r     <= '0;
            start_r     <= 1'b0;
            sclk_r      <= 1'b0;
            fsx_r       <= 1'b0;
            data_out_r  <= '0;
            ch_out_r    <= 3'd0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            drdy_meta_r <= drdy_n;
            drdy_sync_r <= drdy_meta_r;
            drdy_prev_r <= drdy_sync_r;
            valid_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r    <= 1'b0;
                    fsx_r     <= 1'b0;
                    div_cnt_r <= '0;
                    if (measure) begin
                        start_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        overrun_r   <= 1'b0;
                        bit_cnt_r   <= '0;
                        ch_cnt_r    <= 3'd0;
                        frame_cnt_r <= '0;
                    end
                end
                ST_ARM: begin
                    sclk_r    <= 1'b0;
                    div_cnt_r <= '0;
                    if (fall_s) begin
                        fsx_r <= 1'b1;
                    end
                end
                ST_SHIFT, ST_EMIT: begin
                    // The divider keeps running through EMIT so the sclk
                    // period stays regular across word boundaries.
                    if (div_hit_s) begin
                        div_cnt_r <= '0;
                        sclk_r    <= ~sclk_r;
                        if (sclk_r) begin
                            fsx_r <= 1'b0;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                    if (fall_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (state_r == ST_SHIFT) begin
                        if (rise_s) begin
                            shift_r <= word_s;
                            if (word_done_s) begin
                                bit_cnt_r <= '0;
`ifdef ADS_CAPTURE_AVG_EN
                                if (last_fr_s) begin
                                    data_out_r <= avg_s[DATA_WIDTH-1:0];
                                    ch_out_r   <= ch_cnt_r;
                                    valid_r    <= 1'b1;
                                end
`else
                                data_out_r <= word_s;
                                ch_out_r   <= ch_cnt_r;
                                valid_r    <= 1'b1;
`endif
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end else begin
                        // EMIT: advance channel/frame; leaving the frame
                        // parks sclk low ahead of the next data-ready.
                        if (!last_ch_s) begin
                            ch_cnt_r <= ch_cnt_r + 3'd1;
                        end else begin
                            ch_cnt_r  <= 3'd0;
                            sclk_r    <= 1'b0;
                            div_cnt_r <= '0;
                            if (!last_fr_s) begin
                                frame_cnt_r <= frame_cnt_r + FR_W'(1);
                            end else begin
                                frame_cnt_r <= '0;
                                start_r     <= 1'b0;
                                busy_r      <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    sclk_r    <= 1'b0;
                    div_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ads_capture_mc.sv
`timescale 1ns/1ps
module tb_ads_capture_mc;

    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic measure1 = 1'b0;
    logic measure4 = 1'b0;
    logic drdy_n = 1'b1;
    logic drr = 1'b0;

    logic          start1, sclk1, fsx1, valid1, busy1, overrun1;
    logic [DW-1:0] data1;
    logic [2:0]    ch1;
    logic          start4, sclk4, fsx4, valid4, busy4, overrun4;
    logic [DW-1:0] data4;
    logic [2:0]    ch4;
    logic          sclk_any;

    typedef struct packed {
        logic [2:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int n_vec = 0;
    int n_err = 0;
    int n_valid4 = 0;
    int cyc = 0;
    int rise1 = 0;
    int fsx1_cnt = 0;
    int rise_prev = 0;
    int rise_last = 0;
    logic sclk1_prev = 1'b0;

    logic [DW-1:0] c0 [4];
    logic [DW-1:0] c1 [4];

    always #5 clk = ~clk;

    assign sclk_any = sclk1 | sclk4;

    ads_capture_mc #(.DATA_WIDTH(DW), .NUM_CH(2), .SCLK_DIV(2), .NUM_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .measure(measure1), .drdy_n(drdy_n), .drr(drr),
        .start(start1), .sclk(sclk1), .fsx(fsx1), .data_out(data1), .ch_out(ch1),
        .valid(valid1), .busy(busy1), .overrun(overrun1)
    );

    ads_capture_mc #(.DATA_WIDTH(DW), .NUM_CH(2), .SCLK_DIV(2), .NUM_FRAMES(4)) dut4 (
        .clk(clk), .rst(rst), .measure(measure4), .drdy_n(drdy_n), .drr(drr),
        .start(start4), .sclk(sclk4), .fsx(fsx4), .data_out(data4), .ch_out(ch4),
        .valid(valid4), .busy(busy4), .overrun(overrun4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: sclk statistics for dut1 and scoreboard pops on each strobe.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sclk1 && !sclk1_prev) begin
            rise1++;
            rise_prev = rise_last;
            rise_last = cyc;
        end
        sclk1_prev = sclk1;
        if (fsx1) fsx1_cnt++;
        if (valid1) begin
            chk("dut1_busy_during_valid", {31'd0, busy1}, 32'd1);
            if (q1.size() == 0) begin
                chk("dut1_unexpected_valid", {31'd0, valid1}, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("dut1_ch", {29'd0, ch1}, {29'd0, e.ch});
                chk("dut1_data", {8'd0, data1}, {8'd0, e.data});
            end
        end
        if (valid4) begin
            n_valid4++;
            if (q4.size() == 0) begin
                chk("dut4_unexpected_valid", {31'd0, valid4}, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("dut4_ch", {29'd0, ch4}, {29'd0, e.ch});
                chk("dut4_data", {8'd0, data4}, {8'd0, e.data});
            end
        end
    end

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 1) measure1 = 1'b1;
        else            measure4 = 1'b1;
        @(negedge clk);
        measure1 = 1'b0;
        measure4 = 1'b0;
    endtask

    // ADC model: drop data-ready with the MSB on drr, then present the next
    // bit after every sclk falling edge. inject >= 0 re-drops data-ready at
    // that bit index to provoke an overrun.
    task automatic adc_frame(input logic [2*DW-1:0] bits, input int nbits, input int inject);
        logic prev;
        bit seen;
        drdy_n = 1'b0;
        drr = bits[2*DW-1];
        repeat (4) @(posedge clk);
        #1 drdy_n = 1'b1;
        for (int i = 1; i < nbits; i++) begin
            seen = 1'b0;
            prev = sclk_any;
            for (int k = 0; k < 64 && !seen; k++) begin
                @(posedge clk);
                #1;
                if (prev && !sclk_any) seen = 1'b1;
                prev = sclk_any;
            end
            if (!seen) timeout_fail("sclk_fall");
            drr = bits[2*DW-1-i];
            if (inject >= 0 && i == inject)     drdy_n = 1'b0;
            if (inject >= 0 && i == inject + 2) drdy_n = 1'b1;
        end
    endtask

    task automatic wait_idle(input int which);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (which == 1 && !busy1) done = 1'b1;
            if (which == 4 && !busy4) done = 1'b1;
        end
        if (!done) timeout_fail("wait_idle");
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0;
        bit seen;
        c0 = '{24'h000064, 24'h0000C8, 24'h00012C, 24'hFFFF38};
        c1 = '{24'h000010, 24'h000020, 24'h000030, 24'h000040};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", {31'd0, start1}, 32'd0);
        chk("rst_sclk", {31'd0, sclk1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_valid", {31'd0, valid1}, 32'd0);
        chk("rst_data", {8'd0, data1}, 32'd0);
        chk("rst_overrun", {31'd0, overrun1}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // One frame, two words, sclk shape
        pulse(1);
        chk("a_busy_armed", {31'd0, busy1}, 32'd1);
        chk("a_start_armed", {31'd0, start1}, 32'd1);
        q1.push_back({3'd0, 24'hA5A5A5});
        q1.push_back({3'd1, 24'h123456});
        #1;
        r0 = rise1;
        f0 = fsx1_cnt;
        adc_frame({24'hA5A5A5, 24'h123456}, 48, -1);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (valid1 && ch1 == 3'd1) seen = 1'b1;
        end
        if (!seen) timeout_fail("a_last_valid");
        chk("a_busy_at_last", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        chk("a_busy_after", {31'd0, busy1}, 32'd0);
        chk("a_start_after", {31'd0, start1}, 32'd0);
        #1;
        chk("a_sclk_rises", 32'(rise1 - r0), 32'd48);
        chk("a_sclk_period", 32'(rise_last - rise_prev), 32'd4);
        chk("a_fsx_cycles", 32'(fsx1_cnt - f0), 32'd4);
        chk("a_overrun", {31'd0, overrun1}, 32'd0);
        repeat (4) @(negedge clk);

        // Overrun: second data-ready mid-shift
        pulse(1);
        q1.push_back({3'd0, 24'h0F0F0F});
        q1.push_back({3'd1, 24'hFEDCBA});
        adc_frame({24'h0F0F0F, 24'hFEDCBA}, 48, 10);
        wait_idle(1);
        chk("b_overrun_set", {31'd0, overrun1}, 32'd1);
        repeat (4) @(negedge clk);
        chk("b_overrun_sticky", {31'd0, overrun1}, 32'd1);
        pulse(1);
        chk("b_overrun_cleared", {31'd0, overrun1}, 32'd0);
        chk("b_busy_rearmed", {31'd0, busy1}, 32'd1);
        q1.push_back({3'd0, 24'h000001});
        q1.push_back({3'd1, 24'h800000});
        adc_frame({24'h000001, 24'h800000}, 48, -1);
        wait_idle(1);
        chk("b_overrun_clean_run", {31'd0, overrun1}, 32'd0);
        repeat (4) @(negedge clk);

        // Four-frame run, measure pulsed while busy
        pulse(4);
`ifdef ADS_CAPTURE_AVG_EN
        q4.push_back({3'd0, 24'h000064});
        q4.push_back({3'd1, 24'h000028});
`else
        for (int f = 0; f < 4; f++) begin
            q4.push_back({3'd0, c0[f]});
            q4.push_back({3'd1, c1[f]});
        end
`endif
        for (int f = 0; f < 4; f++) begin
            adc_frame({c0[f], c1[f]}, 48, -1);
            repeat (8) @(posedge clk);
            if (f == 1) begin
                pulse(4);
                chk("c_busy_mid_run", {31'd0, busy4}, 32'd1);
                chk("c_start_mid_run", {31'd0, start4}, 32'd1);
            end
        end
        wait_idle(4);
`ifdef ADS_CAPTURE_AVG_EN
        chk("c_strobe_count", 32'(n_valid4), 32'd2);
`else
        chk("c_strobe_count", 32'(n_valid4), 32'd8);
`endif
        chk("c_overrun", {31'd0, overrun4}, 32'd0);
        repeat (4) @(negedge clk);

        // Reset after 10 bits of a word
        pulse(1);
        adc_frame({24'hC3C3C3, 24'h3C3C3C}, 10, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("d_busy_before_rst", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("d_start", {31'd0, start1}, 32'd0);
        chk("d_sclk", {31'd0, sclk1}, 32'd0);
        chk("d_fsx", {31'd0, fsx1}, 32'd0);
        chk("d_valid", {31'd0, valid1}, 32'd0);
        chk("d_busy", {31'd0, busy1}, 32'd0);
        chk("d_overrun", {31'd0, overrun1}, 32'd0);
        chk("d_data", {8'd0, data1}, 32'd0);
        chk("d_ch", {29'd0, ch1}, 32'd0);
        drdy_n = 1'b1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("d_idle_after_rst", {31'd0, busy1}, 32'd0);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ads_capture_mc.md
ADS_CAPTURE_MC -- requirements
Module: ads_capture_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, bits per conversion word.
REQ-002 SHALL have parameter NUM_CH, default 2, daisy-chained ADC channels per frame (1..8).
REQ-003 SHALL have parameter SCLK_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-004 SHALL have parameter NUM_FRAMES, default 4, frames captured per measure pulse (1..65535).
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port measure  input  1  one-cycle pulse that starts a capture run.
REQ-008 SHALL have port drdy_n  input  1  ADC data-ready, active-low, asynchronous to clk.
REQ-009 SHALL have port drr  input  1  serial data from ADC, MSB first.
REQ-010 SHALL have port start  output  1  ADC START pin, high while a run is active.
REQ-011 SHALL have port sclk  output  1  serial shift clock to ADC.
REQ-012 SHALL have port fsx  output  1  frame sync, high for the first sclk period of each frame.
REQ-013 SHALL have port data_out  output  DATA_WIDTH  last completed word.
REQ-014 SHALL have port ch_out  output  3  channel index of data_out.
REQ-015 SHALL have port valid  output  1  one-cycle strobe qualifying data_out/ch_out.
REQ-016 SHALL have port busy  output  1  high from ARM through the last emitted word.
REQ-017 SHALL have port overrun  output  1  sticky: drdy_n fell during SHIFT.

Function
REQ-018 SHALL synchronise drdy_n through two flops; a falling edge is detected on the synchronised value (3-cycle detection latency).
REQ-019 SHALL implement states IDLE, ARM, SHIFT, EMIT; IDLE->ARM on measure; ARM->SHIFT on detected drdy_n fall; SHIFT->EMIT after each DATA_WIDTH bits; EMIT->SHIFT if channels remain in frame, EMIT->ARM if frames remain, else EMIT->IDLE.
REQ-020 SHALL ignore measure while busy=1.
REQ-021 SHALL hold sclk low in IDLE/ARM and toggle it every SCLK_DIV clk cycles in SHIFT, starting with a rising edge.
REQ-022 SHALL sample drr on the clk cycle producing each sclk rising edge and shift it in MSB first.
REQ-023 SHALL assert valid exactly one clk cycle (EMIT) after the last bit of a word is sampled, with ch_out=0..NUM_CH-1 in chain order.
REQ-024 SHALL hold data_out and ch_out stable between valid strobes.
REQ-025 SHALL produce NUM_CH*DATA_WIDTH sclk rising edges per frame and NUM_FRAMES*NUM_CH valid strobes per run.
REQ-026 SHALL set overrun on a detected drdy_n fall while in SHIFT or EMIT, continue the current frame unchanged, and clear overrun only on the next accepted measure or reset.
REQ-027 SHALL deassert start and busy in the same cycle as the EMIT->IDLE transition.

Reset
REQ-028 SHALL on rst force state IDLE, start=0, sclk=0, fsx=0, valid=0, busy=0, overrun=0, data_out=0, ch_out=0, counters=0, synchroniser flops=1.
REQ-029 SHALL, on rst mid-run, abandon the partial word without emitting valid.

Configuration
REQ-030 SHALL, when macro ADS_CAPTURE_AVG_EN is defined, accumulate each channel over all NUM_FRAMES frames (accumulator width DATA_WIDTH+16, signed) and emit only NUM_CH words at run end, each the accumulated sum arithmetic-right-shifted by log2(NUM_FRAMES); NUM_FRAMES SHALL then be a power of two.
REQ-031 SHALL, without ADS_CAPTURE_AVG_EN, emit every word as captured (REQ-025) and contain no accumulator logic.

Verification
REQ-032 SHALL cover: DATA_WIDTH=24, NUM_CH=2, NUM_FRAMES=1, ADC model drives 0xA5A5A5 then 0x123456 -> valid twice, ch_out 0 then 1, data_out matching, busy falls after second strobe.
REQ-033 SHALL cover: SCLK_DIV=2, one frame -> exactly 48 sclk rising edges, sclk period 4 clk cycles, fsx high for first 4 cycles.
REQ-034 SHALL cover: second drdy_n fall injected mid-SHIFT -> overrun=1, both words still correct, overrun cleared by next measure.
REQ-035 SHALL cover: measure pulsed while busy -> no restart, strobe count stays NUM_FRAMES*NUM_CH=8.
REQ-036 SHALL cover: rst asserted after 10 bits of a word -> all outputs at reset values next cycle, no valid strobe.
REQ-037 SHALL cover, with ADS_CAPTURE_AVG_EN and NUM_FRAMES=4: ch0 samples 100,200,300,-200 -> single ch0 word 100 (0x000064).
